// File: rtl/mac_result_drain.sv
// Result drain behind the signed MAC accumulator: round-half-up, arithmetic shift and
// saturate each final value, then buffer it in a small FIFO exposed as a valid/ready stream.
module mac_result_drain #(
  parameter int D_W_ACC = 32,
  parameter int D_W_OUT = 16,
  parameter int SHIFT   = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_W_ACC-1:0]         acc_in,
  input  logic                       acc_last,
  output logic [D_W_OUT-1:0]         out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clr_err,
  output logic                       ovf,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = D_W_ACC + 1;

  localparam logic [XW-1:0] ONE = 1;
  // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
  localparam logic signed [XW-1:0] RND  = (ONE << SHIFT) >> 1;
  localparam logic signed [XW-1:0] MAXV = (ONE << (D_W_OUT - 1)) - ONE;
  localparam logic signed [XW-1:0] MINV = ~MAXV;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rounded;
  logic signed [XW-1:0] shifted;
  logic [D_W_OUT-1:0]   res_data;
  logic                 res_sat;

  logic                 stage_valid;
  logic [D_W_OUT-1:0]   stage_data;
  logic                 stage_sat;

  logic [D_W_OUT:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 drop;

  always_comb begin
    ext      = {acc_in[D_W_ACC-1], acc_in};
    rounded  = ext + RND;
    shifted  = rounded >>> SHIFT;
    res_data = shifted[D_W_OUT-1:0];
    res_sat  = 1'b0;
    if (shifted > MAXV) begin
      res_data = MAXV[D_W_OUT-1:0];
      res_sat  = 1'b1;
    end else if (shifted < MINV) begin
      res_data = MINV[D_W_OUT-1:0];
      res_sat  = 1'b1;
    end
  end

  // Stage never stalls: a new final value is accepted every cycle it is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_sat   <= 1'b0;
    end else begin
      stage_valid <= acc_last;
      if (acc_last) begin
        stage_data <= res_data;
        stage_sat  <= res_sat;
      end
    end
  end

  // Stream handshake: the head transfers on a cycle where out_valid and out_ready are both high;
  // out_valid never depends on out_ready and the head holds while it waits.
  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = stage_valid && (!full || pop);
  assign drop      = stage_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {stage_sat, stage_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign out_data = mem[rd_ptr][D_W_OUT-1:0];
  assign out_sat  = mem[rd_ptr][D_W_OUT];

  // A drop in the same cycle as a clear is counted after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_err) begin
      ovf      <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
